// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, op-field bit
// positions, iteration count and two's-complement helpers.
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    // Bit positions inside the decoder's op fields
    localparam int unsigned MULT_S = 0;
    localparam int unsigned MULT_U = 1;
    localparam int unsigned DIV_S  = 0;
    localparam int unsigned DIV_U  = 1;
    localparam int unsigned MFLO   = 0;
    localparam int unsigned MFHI   = 1;
    localparam int unsigned MTLO   = 0;
    localparam int unsigned MTHI   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2,
        MUL_RUN = 2'd3
    } mdu_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_DIV  = 2'd1,
        OP_MUL  = 2'd2,
        OP_MT   = 2'd3
    } mdu_op_e;

    function automatic logic [XLEN-1:0] neg32_if(input logic neg, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*XLEN-1:0] neg64_if(input logic neg, input logic [2*XLEN-1:0] v);
        logic [2*XLEN-1:0] r;
        if (neg) begin
            r = ~v + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative magnitude engine: restoring divide and radix-2 shift-add multiply
// sharing one 64-bit accumulator and the 5-bit iteration counter.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            start,
    input  logic            start_mul,
    input  logic            start_signed,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            step,
    output logic            last,
    output logic [XLEN-1:0] div_hi,
    output logic [XLEN-1:0] div_lo,
    output logic [XLEN-1:0] mul_hi,
    output logic [XLEN-1:0] mul_lo
);

    logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  a_raw_q, a_raw_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mul_q, mul_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dvz_q, dvz_d;

    logic             a_neg_s, b_neg_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s;
    logic [XLEN:0]    div_shift_s, div_diff_s, mul_sum_s;
    logic [XLEN-1:0]  div_hi_step_s, div_lo_step_s;
    logic [XLEN-1:0]  mul_hi_step_s, mul_lo_step_s;
    logic [2*XLEN-1:0] mul_prod_s, mul_fix_s;

    // One restoring-divide step and one shift-add step, selected later by mode
    always_comb begin
        a_neg_s = start_signed & op_a[XLEN-1];
        b_neg_s = start_signed & op_b[XLEN-1];
        a_mag_s = neg32_if(a_neg_s, op_a);
        b_mag_s = neg32_if(b_neg_s, op_b);

        div_shift_s = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, dvs_q};
        if (div_diff_s[XLEN]) begin
            div_hi_step_s = div_shift_s[XLEN-1:0];
        end else begin
            div_hi_step_s = div_diff_s[XLEN-1:0];
        end
        div_lo_step_s = {acc_lo_q[XLEN-2:0], ~div_diff_s[XLEN]};

        if (acc_lo_q[0]) begin
            mul_sum_s = {1'b0, acc_hi_q} + {1'b0, dvs_q};
        end else begin
            mul_sum_s = {1'b0, acc_hi_q};
        end
        mul_hi_step_s = mul_sum_s[XLEN:1];
        mul_lo_step_s = {mul_sum_s[0], acc_lo_q[XLEN-1:1]};
    end

    // Next-state: abort, load magnitudes on start, or iterate
    always_comb begin
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        dvs_d     = dvs_q;
        a_raw_d   = a_raw_q;
        count_d   = count_q;
        mul_d     = mul_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dvz_d     = dvz_q;
        if (clr) begin
            count_d = 5'd0;
        end else if (start) begin
            count_d   = 5'd0;
            mul_d     = start_mul;
            acc_hi_d  = 32'd0;
            quo_neg_d = a_neg_s ^ b_neg_s;
            rem_neg_d = a_neg_s;
            a_raw_d   = op_a;
            dvz_d     = (op_b == 32'd0);
            if (start_mul) begin
                acc_lo_d = b_mag_s;
                dvs_d    = a_mag_s;
            end else begin
                acc_lo_d = a_mag_s;
                dvs_d    = b_mag_s;
            end
        end else if (step) begin
            count_d = count_q + 5'd1;
            if (mul_q) begin
                acc_hi_d = mul_hi_step_s;
                acc_lo_d = mul_lo_step_s;
            end else begin
                acc_hi_d = div_hi_step_s;
                acc_lo_d = div_lo_step_s;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Engine registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            dvs_q     <= 32'd0;
            a_raw_q   <= 32'd0;
            count_q   <= 5'd0;
            mul_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            dvs_q     <= dvs_d;
            a_raw_q   <= a_raw_d;
            count_q   <= count_d;
            mul_q     <= mul_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dvz_q     <= dvz_d;
        end
    end

    // Sign fix; the multiply result is taken from the final step so HI/LO can
    // be written on the same edge that would retire the last iteration.
    always_comb begin
        last = (count_q == LAST_CNT);
        if (dvz_q) begin
            div_lo = 32'hFFFF_FFFF;
            div_hi = a_raw_q;
        end else begin
            div_lo = neg32_if(quo_neg_q, acc_lo_q);
            div_hi = neg32_if(rem_neg_q, acc_hi_q);
        end
        mul_prod_s = {mul_sum_s, acc_lo_q[XLEN-1:1]};
        mul_fix_s  = neg64_if(quo_neg_q, mul_prod_s);
        mul_hi     = mul_fix_s[2*XLEN-1:XLEN];
        mul_lo     = mul_fix_s[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO, FSM and pipeline stall.
// Build option: MDU_FAST_MUL_EN selects a single-cycle array multiplier.
module mdu_hilo
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [1:0]      MULT,
    input  logic [1:0]      DIV,
    input  logic [1:0]      MFHL,
    input  logic [1:0]      MTHL,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] hl_rdata,
    output logic            mdu_stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_e      state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    mdu_op_e         op_kind_s;
    logic            op_signed_s;
    logic            accept_s;
    logic            div_start_s;
    logic            mul_start_s;
    logic            core_step_s;
    logic            core_last_s;
    logic [XLEN-1:0] div_hi_s, div_lo_s, mul_hi_s, mul_lo_s;

    // Illegal multi-field ops resolve DIV > MULT > MTHL; bit 0 wins inside a field
    always_comb begin
        if (|DIV) begin
            op_kind_s   = OP_DIV;
            op_signed_s = DIV[DIV_S];
        end else if (|MULT) begin
            op_kind_s   = OP_MUL;
            op_signed_s = MULT[MULT_S];
        end else if (|MTHL) begin
            op_kind_s   = OP_MT;
            op_signed_s = 1'b0;
        end else begin
            op_kind_s   = OP_NONE;
            op_signed_s = 1'b0;
        end
        accept_s = in_valid & ~flush & (state_q == IDLE);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;

    // Single-cycle array product
    always_comb begin
        if (MULT[MULT_S]) begin
            fast_prod_s = $signed({{XLEN{src_a[XLEN-1]}}, src_a}) * $signed({{XLEN{src_b[XLEN-1]}}, src_b});
        end else begin
            fast_prod_s = {32'd0, src_a} * {32'd0, src_b};
        end
    end
`endif

    // FSM next state and HI/LO write selection
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start_s = 1'b0;
        mul_start_s = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        case (op_kind_s)
                            OP_DIV: begin
                                div_start_s = 1'b1;
                                state_d     = DIV_RUN;
                            end
                            OP_MUL: begin
`ifdef MDU_FAST_MUL_EN
                                hi_d = fast_prod_s[2*XLEN-1:XLEN];
                                lo_d = fast_prod_s[XLEN-1:0];
`else
                                mul_start_s = 1'b1;
                                state_d     = MUL_RUN;
`endif
                            end
                            OP_MT: begin
                                if (MTHL[MTLO]) begin
                                    lo_d = src_a;
                                end else begin
                                    hi_d = src_a;
                                end
                            end
                            default: state_d = IDLE;
                        endcase
                    end else begin
                        state_d = IDLE;
                    end
                end
                DIV_RUN: begin
                    if (core_last_s) begin
                        state_d = DIV_FIX;
                    end else begin
                        state_d = DIV_RUN;
                    end
                end
                DIV_FIX: begin
                    hi_d    = div_hi_s;
                    lo_d    = div_lo_s;
                    state_d = IDLE;
                end
`ifndef MDU_FAST_MUL_EN
                MUL_RUN: begin
                    if (core_last_s) begin
                        hi_d    = mul_hi_s;
                        lo_d    = mul_lo_s;
                        state_d = IDLE;
                    end else begin
                        state_d = MUL_RUN;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        core_step_s = (state_q == DIV_RUN) | (state_q == MUL_RUN);
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    mdu_div_core u_core (
        .clk          (clk),
        .reset        (reset),
        .clr          (flush),
        .start        (div_start_s | mul_start_s),
        .start_mul    (mul_start_s),
        .start_signed (op_signed_s),
        .op_a         (src_a),
        .op_b         (src_b),
        .step         (core_step_s),
        .last         (core_last_s),
        .div_hi       (div_hi_s),
        .div_lo       (div_lo_s),
        .mul_hi       (mul_hi_s),
        .mul_lo       (mul_lo_s)
    );

    // Read port, stall and debug outputs
    always_comb begin
        if (MFHL[MFHI]) begin
            hl_rdata = hi_q;
        end else if (MFHL[MFLO]) begin
            hl_rdata = lo_q;
        end else begin
            hl_rdata = 32'd0;
        end
        busy      = (state_q != IDLE);
        mdu_stall = in_valid & ~flush & busy & (|{MULT, DIV, MFHL, MTHL});
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: MF reads are checked by a monitor against
// values predicted by an arithmetic HI/LO model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush;
    logic [1:0]  MULT, DIV, MFHL, MTHL;
    logic [31:0] src_a, src_b, hl_rdata, hi, lo;
    logic        mdu_stall, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] hi_m, lo_m;
    logic [31:0] mon_e;
    string       mon_nm;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 32;
`endif

    mdu_hilo dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .MULT(MULT), .DIV(DIV), .MFHL(MFHL), .MTHL(MTHL),
        .src_a(src_a), .src_b(src_b), .hl_rdata(hl_rdata),
        .mdu_stall(mdu_stall), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, expv);
        end
    endtask

    // Monitor: every MF the DUT completes is matched against the queue head
    always @(negedge clk) begin
        if (!reset && in_valid && !flush && MFHL != 2'b00 && !mdu_stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mf_unexpected: got %08h expected no read", hl_rdata);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                check(mon_nm, hl_rdata, mon_e);
            end
        end
    end

    // Reference model: MIPS semantics in plain arithmetic
    function automatic void ref_exec(input logic [1:0] mu, input logic [1:0] dv,
                                     input logic [1:0] mt, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r, p;
        logic [63:0] up;
        if (dv != 2'b00) begin
            if (b == 32'd0) begin
                lo_m = 32'hFFFF_FFFF;
                hi_m = a;
            end else if (dv[0]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                lo_m = q[31:0];
                hi_m = r[31:0];
            end else begin
                lo_m = a / b;
                hi_m = a % b;
            end
        end else if (mu != 2'b00) begin
            if (mu[0]) begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32];
                lo_m = p[31:0];
            end else begin
                up = {32'd0, a} * {32'd0, b};
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
        end else if (mt[0]) begin
            lo_m = a;
        end else if (mt[1]) begin
            hi_m = a;
        end
    endfunction

    // Present one instruction until it is no longer stalled; called just after a posedge
    task automatic issue(input logic [1:0] mu, input logic [1:0] dv, input logic [1:0] mf,
                         input logic [1:0] mt, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        stalls = 0;
        MULT = mu; DIV = dv; MFHL = mf; MTHL = mt; src_a = a; src_b = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!mdu_stall) break;
            stalls++;
        end
        if (stalls >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got %0d stall cycles expected under 200", stalls);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; MULT = 2'b00; DIV = 2'b00; MFHL = 2'b00; MTHL = 2'b00;
    endtask

    task automatic do_op(input logic [1:0] mu, input logic [1:0] dv, input logic [1:0] mt,
                         input logic [31:0] a, input logic [31:0] b);
        int st;
        issue(mu, dv, 2'b00, mt, a, b, st);
        ref_exec(mu, dv, mt, a, b);
    endtask

    task automatic mf(input logic sel_hi, input logic [31:0] expv, input string nm, output int stalls);
        exp_q.push_back(expv);
        name_q.push_back(nm);
        issue(2'b00, 2'b00, sel_hi ? 2'b10 : 2'b01, 2'b00, 32'd0, 32'd0, stalls);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int          st;
        logic [31:0] sv_hi, sv_lo, ra, rb;
        logic [1:0]  mu, dv, mt;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        MULT = 2'b00; DIV = 2'b00; MFHL = 2'b00; MTHL = 2'b00; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, mdu_stall}, 32'd0);
        check("reset_rdata", hl_rdata, 32'd0);
        @(posedge clk); #1;

        // Directed multiplies with latency measured by a back-to-back MF
        do_op(2'b01, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd3);
        mf(1'b0, 32'hFFFF_FFFA, "mult_lo", st);
        check("mult_latency", 32'(st), 32'(MUL_STALLS));
        mf(1'b1, 32'hFFFF_FFFF, "mult_hi", st);
        do_op(2'b10, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd3);
        mf(1'b0, 32'hFFFF_FFFA, "multu_lo", st);
        check("multu_latency", 32'(st), 32'(MUL_STALLS));
        mf(1'b1, 32'h0000_0002, "multu_hi", st);

        // Directed divides
        do_op(2'b00, 2'b01, 2'b00, 32'hFFFF_FFF9, 32'd2);
        mf(1'b1, 32'hFFFF_FFFF, "div_hi", st);
        check("div_stall_cycles", 32'(st), 32'd33);
        mf(1'b0, 32'hFFFF_FFFD, "div_lo", st);
        do_op(2'b00, 2'b10, 2'b00, 32'hFFFF_FFF9, 32'd2);
        mf(1'b0, 32'h7FFF_FFFC, "divu_lo", st);
        mf(1'b1, 32'h0000_0001, "divu_hi", st);
        do_op(2'b00, 2'b01, 2'b00, 32'h1234_5678, 32'd0);
        mf(1'b1, 32'h1234_5678, "div0_hi", st);
        mf(1'b0, 32'hFFFF_FFFF, "div0_lo", st);
        do_op(2'b00, 2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        mf(1'b0, 32'h8000_0000, "divovf_lo", st);
        mf(1'b1, 32'h0000_0000, "divovf_hi", st);
        // Illegal combination: signed DIV wins over MULT and MTHL
        do_op(2'b01, 2'b11, 2'b10, 32'hFFFF_FF9C, 32'd7);
        mf(1'b0, 32'hFFFF_FFF2, "prio_lo", st);
        mf(1'b1, 32'hFFFF_FFFE, "prio_hi", st);

        // MTHI, then flush a divide at cycle 10
        do_op(2'b00, 2'b00, 2'b10, 32'hAAAA_0000, 32'd0);
        mf(1'b1, 32'hAAAA_0000, "mthi_read", st);
        check("mthi_read_stall", 32'(st), 32'd0);
        sv_hi = hi_m; sv_lo = lo_m;
        do_op(2'b00, 2'b01, 2'b00, 32'd1000, 32'd3);
        hi_m = sv_hi; lo_m = sv_lo;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b1;
        @(negedge clk);
        check("nonmdu_stall", {31'd0, mdu_stall}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'hAAAA_0000);
        in_valid = 1'b1; MTHL = 2'b01; src_a = 32'h0000_0055;
        #1;
        check("mtlo_after_flush_stall", {31'd0, mdu_stall}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; MTHL = 2'b00;
        lo_m = 32'h0000_0055;
        mf(1'b0, 32'h0000_0055, "mtlo_after_flush", st);
        mf(1'b1, 32'hAAAA_0000, "hi_after_flush", st);

        // Reset held two cycles mid-divide
        do_op(2'b00, 2'b10, 2'b00, 32'hDEAD_BEEF, 32'd7);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        mf(1'b1, 32'd0, "midreset_mfhi", st);

        // Randomised ops against the model
        for (int n = 0; n < 80; n++) begin
            mu = 2'b00; dv = 2'b00; mt = 2'b00;
            case ($urandom_range(0, 5))
                0: mu = 2'b01;
                1: mu = 2'b10;
                2: dv = 2'b01;
                3: dv = 2'b10;
                4: mt = 2'b10;
                default: mt = 2'b01;
            endcase
            ra = pick();
            rb = pick();
            do_op(mu, dv, mt, ra, rb);
            if ($urandom_range(0, 1) == 0) begin
                mf(1'b1, hi_m, "rand_hi", st);
                mf(1'b0, lo_m, "rand_lo", st);
            end else begin
                mf(1'b0, lo_m, "rand_lo", st);
                mf(1'b1, hi_m, "rand_hi", st);
            end
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
